garage_door_sequencer: RTL and testbench

// - Top-level sequencer for the garage door motor: arbitrates open/close requests from wall button and remote.
// - Drives Up_M/Dn_M with enforced motor-off dead-time, obstruction auto-reverse and travel timeout fault.
// - Sits between user inputs, limit switches/IR beam and the motor driver.

---
 rtl/garage_door_sequencer_if.sv | 37 +++
 rtl/garage_door_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_garage_door_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/garage_door_sequencer_if.sv
// Garage door sequencer I/O bundle.
// Groups the sensor/user inputs and the motor/status outputs of the sequencer.
//   Up_max   : upper limit switch, 1 = fully open
//   Dn_max   : lower limit switch, 1 = fully closed
//   Btn_wall : wall push-button level
//   Btn_rem  : remote receiver level
//   Lock     : 1 = remote requests ignored
//   Obstruct : IR beam broken, 1 = obstacle in doorway
//   Up_M     : motor drive up
//   Dn_M     : motor drive down
//   Busy     : 1 in DEADTIME, OPENING, CLOSING
//   Fault    : 1 in FAULT
// Modports:
//   master : environment side (drives sensors/buttons, observes motor and status)
//   slave  : sequencer side (reads sensors/buttons, drives motor and status)
interface garage_door_sequencer_if;
  logic Up_max;
  logic Dn_max;
  logic Btn_wall;
  logic Btn_rem;
  logic Lock;
  logic Obstruct;
  logic Up_M;
  logic Dn_M;
  logic Busy;
  logic Fault;

  modport master (
    output Up_max, Dn_max, Btn_wall, Btn_rem, Lock, Obstruct,
    input  Up_M, Dn_M, Busy, Fault
  );

  modport slave (
    input  Up_max, Dn_max, Btn_wall, Btn_rem, Lock, Obstruct,
    output Up_M, Dn_M, Busy, Fault
  );
endinterface

// File: rtl/garage_door_sequencer.sv
// Garage door motor sequencer.
// Arbitrates open/close requests from the wall button and the remote, drives the
// up/down motor outputs with a motor-off dead-time before every start, reverses
// on obstruction while closing and faults on travel timeout or on both limit
// switches reading active at once.
// Ports:
//   CLK  : clock, all state on rising edge
//   RST  : asynchronous active-low reset
//   door : garage_door_sequencer_if.slave (limits, buttons, lock, obstruction in;
//          Up_M, Dn_M, Busy, Fault out; all outputs registered)
// Parameters:
//   DEAD_CYC       : cycles both motor outputs are low before any start (>= 1)
//   TRAVEL_MAX     : max cycles in OPENING/CLOSING before FAULT (>= 2)
//   AUTO_CLOSE_CYC : cycles the door stays OPEN before auto-close
//   CNT_W          : shared counter width
// Configuration macro:
//   AUTO_CLOSE_EN  : when defined, an OPEN door closes by itself after
//                    AUTO_CLOSE_CYC cycles without obstruction or press.
module garage_door_sequencer #(
  parameter int unsigned DEAD_CYC       = 4,
  parameter int unsigned TRAVEL_MAX     = 1000,
  parameter int unsigned AUTO_CLOSE_CYC = 5000,
  parameter int unsigned CNT_W          = 16
) (
  input logic                    CLK,
  input logic                    RST,
  garage_door_sequencer_if.slave door
);

  // Elaboration-time sanity checks on the configuration.
  if (DEAD_CYC < 1) begin : g_bad_dead
    $error("DEAD_CYC must be at least 1");
  end
  if (TRAVEL_MAX < 2) begin : g_bad_travel
    $error("TRAVEL_MAX must be at least 2");
  end
  if ($clog2(DEAD_CYC) > CNT_W || $clog2(TRAVEL_MAX) > CNT_W ||
      $clog2(AUTO_CLOSE_CYC) > CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] DeadLast   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX - 1);
`ifdef AUTO_CLOSE_EN
  localparam logic [CNT_W-1:0] AutoLast   = CNT_W'(AUTO_CLOSE_CYC - 1);
`endif

  typedef enum logic [2:0] {
    StStopped,
    StClosed,
    StOpen,
    StDeadtime,
    StOpening,
    StClosing,
    StFault
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tgt_up_q, tgt_up_d;   // direction to start after DEADTIME
  logic               dir_up_q, dir_up_d;   // last direction stopped by a press
  logic               btn_wall_q, btn_rem_q;
  logic               up_m_q, dn_m_q, busy_q, fault_q;
  logic               press;
  logic               target_up;
  logic               cnt_clr;

  // Simultaneous edges on both buttons collapse into a single press.
  assign press = (door.Btn_wall & ~btn_wall_q) |
                 (door.Btn_rem & ~btn_rem_q & ~door.Lock);

  always_comb begin
    state_d   = state_q;
    tgt_up_d  = tgt_up_q;
    dir_up_d  = dir_up_q;
    cnt_clr   = 1'b0;
    target_up = door.Dn_max | ((state_q == StStopped) & ~dir_up_q);

    if (door.Up_max && door.Dn_max) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StFault: state_d = StFault;

        StStopped, StClosed, StOpen: begin
          // A downward start is refused while the beam is broken.
          if (press && (target_up || !door.Obstruct)) begin
            state_d  = StDeadtime;
            tgt_up_d = target_up;
          end
`ifdef AUTO_CLOSE_EN
          else if (state_q == StOpen) begin
            if (door.Obstruct || press) begin
              cnt_clr = 1'b1;
            end else if (cnt_q == AutoLast) begin
              state_d  = StDeadtime;
              tgt_up_d = 1'b0;
            end
          end
`endif
        end

        StDeadtime: begin
          if (press) begin
            state_d = StStopped;
          end else if (cnt_q == DeadLast) begin
            state_d = tgt_up_q ? StOpening : StClosing;
          end
        end

        StOpening: begin
          if (door.Up_max) begin
            state_d = StOpen;
          end else if (press) begin
            state_d  = StStopped;
            dir_up_d = 1'b1;
          end else if (cnt_q == TravelLast) begin
            state_d = StFault;
          end
        end

        StClosing: begin
          if (door.Dn_max) begin
            state_d = StClosed;
          end else if (door.Obstruct) begin
            // Auto-reverse goes through a fresh dead-time before driving up.
            state_d  = StDeadtime;
            tgt_up_d = 1'b1;
          end else if (press) begin
            state_d  = StStopped;
            dir_up_d = 1'b0;
          end else if (cnt_q == TravelLast) begin
            state_d = StFault;
          end
        end

        default: state_d = StStopped;
      endcase
    end

    if (state_d != state_q || cnt_clr) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StStopped;
      cnt_q      <= '0;
      tgt_up_q   <= 1'b0;
      dir_up_q   <= 1'b0;
      btn_wall_q <= 1'b0;
      btn_rem_q  <= 1'b0;
      up_m_q     <= 1'b0;
      dn_m_q     <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_up_q   <= tgt_up_d;
      dir_up_q   <= dir_up_d;
      btn_wall_q <= door.Btn_wall;
      btn_rem_q  <= door.Btn_rem;
      up_m_q     <= (state_d == StOpening);
      dn_m_q     <= (state_d == StClosing);
      busy_q     <= (state_d == StDeadtime) || (state_d == StOpening) ||
                    (state_d == StClosing);
      fault_q    <= (state_d == StFault);
    end
  end

  assign door.Up_M  = up_m_q;
  assign door.Dn_M  = dn_m_q;
  assign door.Busy  = busy_q;
  assign door.Fault = fault_q;

endmodule

// File: tb/tb_garage_door_sequencer.sv
// Directed bench for garage_door_sequencer (DEAD_CYC=4, TRAVEL_MAX=20,
// AUTO_CLOSE_CYC=30). Outputs are compared as {Up_M, Dn_M, Busy, Fault}.
module tb_garage_door_sequencer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  garage_door_sequencer_if door ();

  garage_door_sequencer #(
    .DEAD_CYC      (4),
    .TRAVEL_MAX    (20),
    .AUTO_CLOSE_CYC(30),
    .CNT_W         (16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .door(door)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [3:0] outs();
    return {door.Up_M, door.Dn_M, door.Busy, door.Fault};
  endfunction

  task automatic do_reset();
    RST           = 1'b0;
    door.Up_max   = 1'b0;
    door.Dn_max   = 1'b0;
    door.Btn_wall = 1'b0;
    door.Btn_rem  = 1'b0;
    door.Lock     = 1'b0;
    door.Obstruct = 1'b0;
    step(2);
    RST = 1'b1;
    step(1);
  endtask

  // Wall button held for one edge then released.
  task automatic press_wall();
    door.Btn_wall = 1'b1;
    step(1);
    door.Btn_wall = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (outs() !== 4'b0000) begin
      $display("FAIL reset_outputs: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
  endtask

  task automatic test_open();
    do_reset();
    door.Dn_max = 1'b1;
    press_wall();  // edge k
    if (outs() !== 4'b0010) begin
      $display("FAIL open_busy_at_k: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(3);       // k+3
    if (outs() !== 4'b0010) begin
      $display("FAIL open_deadtime_k3: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(1);       // k+4
    if (outs() !== 4'b1010) begin
      $display("FAIL open_motor_k4: got %b want %b", outs(), 4'b1010);
      failures++;
    end
    checks++;
    door.Dn_max = 1'b0;
    step(6);       // k+10
    door.Up_max = 1'b1;
    step(1);       // k+11
    if (outs() !== 4'b0000) begin
      $display("FAIL open_reached_k11: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
  endtask

  // Starts in OPEN with Up_max=1; ends in OPEN.
  task automatic test_reverse();
    press_wall();  // edge p, target down
    door.Up_max = 1'b0;
    step(4);       // p+4
    if (outs() !== 4'b0110) begin
      $display("FAIL rev_closing: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
    step(2);       // p+6, third cycle of CLOSING follows
    door.Obstruct = 1'b1;
    step(1);       // p+7
    door.Obstruct = 1'b0;
    if (outs() !== 4'b0010) begin
      $display("FAIL rev_motor_off: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(3);       // p+10
    if (outs() !== 4'b0010) begin
      $display("FAIL rev_deadtime_hold: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(1);       // p+11
    if (outs() !== 4'b1010) begin
      $display("FAIL rev_up_motor: got %b want %b", outs(), 4'b1010);
      failures++;
    end
    checks++;
    door.Up_max = 1'b1;
    step(1);
  endtask

  // Starts in OPEN; ends in CLOSED with Dn_max=1.
  task automatic test_close();
    door.Obstruct = 1'b1;
    press_wall();
    if (outs() !== 4'b0000) begin
      $display("FAIL obstruct_blocks_down: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    door.Obstruct = 1'b0;
    step(1);
    press_wall();
    door.Up_max = 1'b0;
    step(4);
    if (outs() !== 4'b0110) begin
      $display("FAIL close_motor: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
    step(2);
    door.Dn_max = 1'b1;
    step(1);
    if (outs() !== 4'b0000) begin
      $display("FAIL close_reached: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
  endtask

  // Starts in CLOSED; ends in STOPPED with dir_last down.
  task automatic test_simultaneous();
    door.Btn_wall = 1'b1;
    door.Btn_rem  = 1'b1;
    step(1);       // edge c
    door.Btn_wall = 1'b0;
    door.Btn_rem  = 1'b0;
    if (outs() !== 4'b0010) begin
      $display("FAIL simul_one_request: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(1);       // c+1
    press_wall();  // c+2
    if (outs() !== 4'b0000) begin
      $display("FAIL simul_cancel: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    step(4);
    if (outs() !== 4'b0000) begin
      $display("FAIL simul_stays_stopped: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
  endtask

  // Starts in STOPPED with Dn_max=1; ends in CLOSED.
  task automatic test_lock();
    door.Lock    = 1'b1;
    door.Btn_rem = 1'b1;
    step(1);
    door.Btn_rem = 1'b0;
    step(4);
    if (outs() !== 4'b0000) begin
      $display("FAIL lock_remote_ignored: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    door.Btn_rem  = 1'b1;
    door.Btn_wall = 1'b1;
    step(1);
    door.Btn_rem  = 1'b0;
    door.Btn_wall = 1'b0;
    if (outs() !== 4'b0010) begin
      $display("FAIL lock_wall_accepted: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(4);
    if (outs() !== 4'b1010) begin
      $display("FAIL lock_single_entry: got %b want %b", outs(), 4'b1010);
      failures++;
    end
    checks++;
    door.Lock   = 1'b0;
    door.Dn_max = 1'b0;
    step(2);
    press_wall();  // stop while opening, dir_last becomes up
    if (outs() !== 4'b0000) begin
      $display("FAIL stop_opening: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    step(1);
    press_wall();
    step(4);
    if (outs() !== 4'b0110) begin
      $display("FAIL stopped_then_down: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
    door.Dn_max = 1'b1;
    step(1);
  endtask

  task automatic test_limit_boundaries();
    do_reset();
    door.Up_max = 1'b1;
    press_wall();
    step(4);
    if (outs() !== 4'b1010) begin
      $display("FAIL limit_start_motor: got %b want %b", outs(), 4'b1010);
      failures++;
    end
    checks++;
    step(1);
    if (outs() !== 4'b0000) begin
      $display("FAIL limit_start_open: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    press_wall();
    door.Up_max = 1'b0;
    step(4);       // CLOSING
    door.Dn_max   = 1'b1;
    door.Btn_wall = 1'b1;  // press and limit on the same edge
    step(1);
    door.Btn_wall = 1'b0;
    door.Dn_max   = 1'b0;
    step(1);
    // From CLOSED with Dn_max=0 the target is down; a STOPPED door would go up.
    press_wall();
    step(4);
    if (outs() !== 4'b0110) begin
      $display("FAIL limit_beats_press: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
    door.Up_max = 1'b1;
    door.Dn_max = 1'b1;
    step(1);
    if (outs() !== 4'b0001) begin
      $display("FAIL both_limits_fault: got %b want %b", outs(), 4'b0001);
      failures++;
    end
    checks++;
  endtask

  task automatic test_timeout();
    do_reset();
    door.Dn_max = 1'b1;
    press_wall();  // k
    step(4);       // k+4
    door.Dn_max = 1'b0;
    step(19);      // k+23
    if (outs() !== 4'b1010) begin
      $display("FAIL timeout_last_motor: got %b want %b", outs(), 4'b1010);
      failures++;
    end
    checks++;
    step(1);       // k+24
    if (outs() !== 4'b0001) begin
      $display("FAIL timeout_fault: got %b want %b", outs(), 4'b0001);
      failures++;
    end
    checks++;
    press_wall();
    step(5);
    if (outs() !== 4'b0001) begin
      $display("FAIL fault_sticky: got %b want %b", outs(), 4'b0001);
      failures++;
    end
    checks++;
    RST = 1'b0;
    #1;
    if (outs() !== 4'b0000) begin
      $display("FAIL fault_async_clear: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    step(1);
    RST = 1'b1;
    step(1);
  endtask

  task automatic test_reset_motion();
    do_reset();
    door.Dn_max = 1'b1;
    press_wall();
    step(4);
    RST = 1'b0;
    #1;            // no clock edge in between
    if (outs() !== 4'b0000) begin
      $display("FAIL async_reset_motion: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    step(1);
    RST = 1'b1;
    step(1);
  endtask

  // Reset, then open against an already active upper limit; OPEN entered on return.
  task automatic goto_open();
    do_reset();
    door.Up_max = 1'b1;
    press_wall();
    step(5);
  endtask

  task automatic test_auto_close();
`ifdef AUTO_CLOSE_EN
    goto_open();   // entry edge e
    step(33);      // e+33
    if (outs() !== 4'b0010) begin
      $display("FAIL autoclose_deadtime: got %b want %b", outs(), 4'b0010);
      failures++;
    end
    checks++;
    step(1);       // e+34
    if (outs() !== 4'b0110) begin
      $display("FAIL autoclose_closing: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
    goto_open();   // e
    step(15);
    door.Obstruct = 1'b1;
    step(1);       // e+16, count restarts
    door.Obstruct = 1'b0;
    step(29);      // e+45
    if (outs() !== 4'b0000) begin
      $display("FAIL autoclose_restart_hold: got %b want %b", outs(), 4'b0000);
      failures++;
    end
    checks++;
    step(5);       // e+50
    if (outs() !== 4'b0110) begin
      $display("FAIL autoclose_restart_close: got %b want %b", outs(), 4'b0110);
      failures++;
    end
    checks++;
`else
    int bad;
    logic [3:0] seen;
    bad  = 0;
    seen = 4'b0000;
    goto_open();
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (outs() !== 4'b0000) begin
        bad++;
        seen = outs();
      end
    end
    if (bad != 0) begin
      $display("FAIL hold_open_100: got %b on %0d cycles want %b", seen, bad, 4'b0000);
      failures++;
    end
    checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_open();
    test_reverse();
    test_close();
    test_simultaneous();
    test_lock();
    test_limit_boundaries();
    test_timeout();
    test_reset_motion();
    test_auto_close();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
